// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC bus scheduler: FSM state encoding,
// write-group select codes and the idle level of the RTC parallel bus.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_ESC,
    ST_WAIT_ESC,
    ST_START_LEE,
    ST_WAIT_LEE,
    ST_GUARD
  } state_t;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_HORA  = 2'b01;
  localparam logic [1:0] SEL_FECHA = 2'b10;
  localparam logic [1:0] SEL_TIMER = 2'b11;

  typedef struct packed {
    logic a_d;
    logic cs;
    logic rd;
    logic wr;
  } bus_t;

  localparam bus_t BUS_IDLE = 4'b1111;

  // Returns {timer, fecha, hora}.
  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    case (sel)
      SEL_HORA:  sel_onehot = 3'b001;
      SEL_FECHA: sel_onehot = 3'b010;
      SEL_TIMER: sel_onehot = 3'b100;
      default:   sel_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_scheduler_if.sv
// Request, engine handshake and RTC bus signals around the scheduler.
// master = user/engine side, slave = scheduler.
interface rtc_bus_scheduler_if;
  logic       req_esc;
  logic [1:0] esc_sel;
  logic       esc_done, lee_done;
  logic       a_d_esc, cs_esc, rd_esc, wr_esc;
  logic       a_d_lee, cs_lee, rd_lee, wr_lee;
  logic       do_it_esc, do_it_lee;
  logic       estado_hora, estado_fecha, estado_timer;
  logic       a_d, cs, rd, wr;
  logic       busy, abort, err;

  modport master (
    output req_esc, esc_sel, esc_done, lee_done,
           a_d_esc, cs_esc, rd_esc, wr_esc,
           a_d_lee, cs_lee, rd_lee, wr_lee,
    input  do_it_esc, do_it_lee, estado_hora, estado_fecha, estado_timer,
           a_d, cs, rd, wr, busy, abort, err
  );

  modport slave (
    input  req_esc, esc_sel, esc_done, lee_done,
           a_d_esc, cs_esc, rd_esc, wr_esc,
           a_d_lee, cs_lee, rd_lee, wr_lee,
    output do_it_esc, do_it_lee, estado_hora, estado_fecha, estado_timer,
           a_d, cs, rd, wr, busy, abort, err
  );
endinterface

// File: rtl/rtc_period_timer.sv
// Free-running 0..PERIOD-1 counter; wrap is high during the last count.
module rtc_period_timer #(
  parameter int PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic wrap
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;

  assign wrap = (cnt == CW'(PERIOD - 1));

  always_ff @(posedge clk or negedge reset)
    if (!reset)    cnt <= '0;
    else if (wrap) cnt <= '0;
    else           cnt <= cnt + CW'(1);
endmodule

// File: rtl/rtc_bus_scheduler.sv
// RTC bus owner: arbitrates user writes over periodic reads, strobes engines,
// muxes the bus with guard gaps. Optional wait timeout: RTC_SCHED_TIMEOUT_EN.
module rtc_bus_scheduler
  import rtc_pkg::*;
#(
  parameter int READ_PERIOD = 10_000_000,
  parameter int TIMEOUT     = 4096,
  parameter int GUARD_CYC   = 4
) (
  input logic                 clk,
  input logic                 reset,
  rtc_bus_scheduler_if.slave  sif
);
  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  state_t        state, state_nx;
  logic          pend_esc, pend_lee, wrap, tmo_hit, guard_done;
  logic [1:0]    sel_q;
  logic [2:0]    estado_q;
  logic [GW-1:0] gcnt;
  bus_t          esc_b, lee_b, bus_o;

  rtc_period_timer #(.PERIOD(READ_PERIOD)) u_period (
    .clk   (clk),
    .reset (reset),
    .wrap  (wrap)
  );

  assign guard_done = (gcnt == GW'(GUARD_CYC - 1));
  assign esc_b = '{sif.a_d_esc, sif.cs_esc, sif.rd_esc, sif.wr_esc};
  assign lee_b = '{sif.a_d_lee, sif.cs_lee, sif.rd_lee, sif.wr_lee};

`ifdef RTC_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] wcnt;
  logic          in_wait, cur_done, abort_q, err_q;

  assign in_wait  = (state == ST_WAIT_ESC) || (state == ST_WAIT_LEE);
  assign cur_done = ((state == ST_WAIT_ESC) && sif.esc_done) ||
                    ((state == ST_WAIT_LEE) && sif.lee_done);
  assign tmo_hit  = in_wait && (wcnt == TW'(TIMEOUT - 1)) && !cur_done;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wcnt    <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wcnt    <= in_wait ? wcnt + TW'(1) : '0;
      abort_q <= tmo_hit;
      err_q   <= err_q | tmo_hit;
    end

  assign sif.abort = abort_q;
  assign sif.err   = err_q;
`else
  // Waits never expire in this build.
  assign tmo_hit   = (TIMEOUT < 0);
  assign sif.abort = 1'b0;
  assign sif.err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (pend_esc)      state_nx = ST_START_ESC;
                    else if (pend_lee) state_nx = ST_START_LEE;
      ST_START_ESC: state_nx = ST_WAIT_ESC;
      ST_WAIT_ESC:  if (sif.esc_done || tmo_hit) state_nx = ST_GUARD;
      ST_START_LEE: state_nx = ST_WAIT_LEE;
      ST_WAIT_LEE:  if (sif.lee_done || tmo_hit) state_nx = ST_GUARD;
      ST_GUARD:     if (guard_done) state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    case (state)
      ST_START_ESC, ST_WAIT_ESC: bus_o = esc_b;
      ST_START_LEE, ST_WAIT_LEE: bus_o = lee_b;
      default:                   bus_o = BUS_IDLE;
    endcase
  end

  assign sif.do_it_esc = (state == ST_START_ESC);
  assign sif.do_it_lee = (state == ST_START_LEE);
  assign sif.busy      = (state != ST_IDLE);
  assign {sif.a_d, sif.cs, sif.rd, sif.wr} = bus_o;
  assign {sif.estado_timer, sif.estado_fecha, sif.estado_hora} = estado_q;

  // A request in the same cycle as the start re-arms pend_esc (set wins).
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pend_esc <= 1'b0;
      pend_lee <= 1'b0;
      sel_q    <= SEL_NONE;
      estado_q <= '0;
      gcnt     <= '0;
    end else begin
      if (sif.req_esc && (sif.esc_sel != SEL_NONE)) begin
        pend_esc <= 1'b1;
        sel_q    <= sif.esc_sel;
      end else if (state_nx == ST_START_ESC) begin
        pend_esc <= 1'b0;
      end
      if (wrap)                            pend_lee <= 1'b1;
      else if (state_nx == ST_START_LEE)   pend_lee <= 1'b0;
      if (state_nx == ST_START_ESC)        estado_q <= sel_onehot(sel_q);
      else if ((state_nx == ST_GUARD) && (state != ST_GUARD)) estado_q <= '0;
      gcnt <= (state == ST_GUARD) ? gcnt + GW'(1) : '0;
    end
endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Scoreboard bench for rtc_bus_scheduler: a transaction-level model predicts
// which engine starts at which cycle; a monitor checks strobes, bus and flags.
module tb_rtc_bus_scheduler;
  localparam int P = 50, TMO = 20, G = 4, L = 10;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  rtc_bus_scheduler_if sif();

  rtc_bus_scheduler #(.READ_PERIOD(P), .TIMEOUT(TMO), .GUARD_CYC(G)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif.slave)
  );

  typedef struct {
    bit         esc;
    logic [2:0] est;
    int         at;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0, errors = 0;
  int   cyc;
  bit   mon_en = 0, stuck = 0, hold_bus = 0;

  // transaction-level model state
  bit         m_pend_esc, m_pend_lee;
  logic [1:0] m_sel;
  int         m_idle_from;
  bit         win_esc;
  logic [2:0] win_est;
  int         win_s, win_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [2:0] group_of(input logic [1:0] s);
    case (s)
      2'b01:   return 3'b001;
      2'b10:   return 3'b010;
      2'b11:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    expq.delete();
    m_pend_esc = 0; m_pend_lee = 0; m_sel = 2'b00; m_idle_from = 0;
    win_esc = 0; win_est = 3'b000; win_s = -100; win_e = -100;
  endtask

  // One call per cycle t with that cycle's request inputs.
  task automatic model_step(input int t, input bit r, input logic [1:0] s);
    exp_t e;
    if (t >= m_idle_from && (m_pend_esc || m_pend_lee)) begin
      e.esc = m_pend_esc;
      e.est = m_pend_esc ? group_of(m_sel) : 3'b000;
      e.at  = t + 1;
      expq.push_back(e);
      win_esc = e.esc; win_est = e.est; win_s = t + 1; win_e = t + 1 + L;
      m_idle_from = t + 1 + L + G + 1;
      if (m_pend_esc) m_pend_esc = 0;
      else            m_pend_lee = 0;
    end
    if (r && s != 2'b00) begin
      m_pend_esc = 1;
      m_sel = s;
    end
    if (t % P == P - 1) m_pend_lee = 1;
  endtask

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (!hold_bus)
      {sif.a_d_esc, sif.cs_esc, sif.rd_esc, sif.wr_esc,
       sif.a_d_lee, sif.cs_lee, sif.rd_lee, sif.wr_lee} = 8'($urandom);
  end

  always begin
    @(negedge clk);
    if (sif.do_it_esc && !stuck) begin
      repeat (L) @(posedge clk);
      #1 sif.esc_done = 1'b1;
      @(posedge clk);
      #1 sif.esc_done = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    if (sif.do_it_lee && !stuck) begin
      repeat (L) @(posedge clk);
      #1 sif.lee_done = 1'b1;
      @(posedge clk);
      #1 sif.lee_done = 1'b0;
    end
  end

  always @(negedge clk) if (mon_en) begin
    int t;
    exp_t e;
    logic [3:0] exp_bus;
    bit inwin, inbusy;
    t = cyc;
    if (sif.do_it_esc || sif.do_it_lee) begin
      if (expq.size() == 0) check("spurious_start", {sif.do_it_esc, sif.do_it_lee}, 0);
      else begin
        e = expq.pop_front();
        check("start_kind", {sif.do_it_esc, sif.do_it_lee}, e.esc ? 2'b10 : 2'b01);
        check("start_cycle", t, e.at);
        check("estado_start", {sif.estado_timer, sif.estado_fecha, sif.estado_hora}, e.est);
      end
    end else if (expq.size() > 0 && expq[0].at < t) begin
      e = expq.pop_front();
      check("missing_start", t, e.at);
    end
    inwin  = (t >= win_s) && (t <= win_e);
    inbusy = (t >= win_s) && (t <= win_e + G);
    if (!inwin)      exp_bus = 4'b1111;
    else if (win_esc) exp_bus = {sif.a_d_esc, sif.cs_esc, sif.rd_esc, sif.wr_esc};
    else             exp_bus = {sif.a_d_lee, sif.cs_lee, sif.rd_lee, sif.wr_lee};
    check("bus", {sif.a_d, sif.cs, sif.rd, sif.wr}, exp_bus);
    check("busy", sif.busy, inbusy);
    check("estado_hold", {sif.estado_timer, sif.estado_fecha, sif.estado_hora},
          (inwin && win_esc) ? win_est : 3'b000);
    check("abort_err", {sif.abort, sif.err}, 2'b00);
  end

  initial begin
    bit r, found;
    logic [1:0] s;
    int t;
    sif.req_esc = 0; sif.esc_sel = 2'b00; sif.esc_done = 0; sif.lee_done = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", sif.busy, 0);
    check("reset_bus", {sif.a_d, sif.cs, sif.rd, sif.wr}, 4'b1111);
    check("reset_strobes", {sif.do_it_esc, sif.do_it_lee}, 2'b00);
    check("reset_estado", {sif.estado_timer, sif.estado_fecha, sif.estado_hora}, 3'b000);
    check("reset_abort_err", {sif.abort, sif.err}, 2'b00);

    // Directed start (write at wrap, queued second write), then random requests.
    @(negedge clk); reset = 1; model_reset(); mon_en = 1; model_step(0, 0, 2'b00);
    for (int k = 1; k < 1600; k++) begin
      @(posedge clk); #1;
      t = cyc; r = 0; s = 2'b00;
      if (t == 49)      begin r = 1; s = 2'b10; end
      else if (t == 55) begin r = 1; s = 2'b11; end
      else if (t > 100) begin r = ($urandom_range(29) == 0); s = 2'($urandom_range(3)); end
      sif.req_esc = r; sif.esc_sel = s;
      model_step(t, r, s);
    end

    // Reset in the middle of a read.
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk); #1;
      sif.req_esc = 0;
      model_step(cyc, 0, 2'b00);
      if (!win_esc && cyc == win_s + 3) found = 1;
    end
    check("find_wait_lee", found, 1);
    mon_en = 0; hold_bus = 1;
    #2 {sif.a_d_lee, sif.cs_lee, sif.rd_lee, sif.wr_lee} = 4'b0000;
    #1 check("pre_reset_bus", {sif.a_d, sif.cs, sif.rd, sif.wr}, 4'b0000);
    reset = 0;
    #1;
    check("async_reset_bus", {sif.a_d, sif.cs, sif.rd, sif.wr}, 4'b1111);
    check("async_reset_busy", sif.busy, 0);
    hold_bus = 0;
    repeat (2) @(posedge clk);
    #1 check("reset_flags", {sif.do_it_esc, sif.do_it_lee, sif.estado_timer,
                             sif.estado_fecha, sif.estado_hora, sif.abort, sif.err}, 0);
    @(negedge clk); reset = 1; model_reset(); mon_en = 1; model_step(0, 0, 2'b00);
    for (int k = 1; k < 130; k++) begin
      @(posedge clk); #1;
      model_step(cyc, 0, 2'b00);
    end

    // Engine that never answers.
    mon_en = 0;
    @(negedge clk); reset = 0; stuck = 1;
    @(negedge clk); reset = 1;
    @(posedge clk); #1 sif.req_esc = 1; sif.esc_sel = 2'b01;
    @(posedge clk); #1 sif.req_esc = 0; sif.esc_sel = 2'b00;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      t = cyc;
      if (t == 3)  check("tmo_start", {sif.do_it_esc, sif.estado_hora}, 2'b11);
`ifdef RTC_SCHED_TIMEOUT_EN
      if (t == 23) check("tmo_before", {sif.abort, sif.err, sif.busy}, 3'b001);
      if (t == 24) check("tmo_abort", {sif.abort, sif.err, sif.busy}, 3'b111);
      if (t == 25) check("tmo_pulse_end", {sif.abort, sif.err, sif.estado_hora}, 3'b010);
      if (t == 27) check("tmo_guard", sif.busy, 1);
      if (t == 28) check("tmo_idle", {sif.busy, sif.err}, 2'b01);
`else
      if (t == 23 || t == 24 || t == 40 || t == 55)
        check("no_tmo_busy", {sif.busy, sif.abort, sif.err}, 3'b100);
`endif
    end
    stuck = 0;
    reset = 0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/rtc_bus_scheduler.md
# rtc_bus_scheduler

Scheduler and bus owner for the RTC parallel bus (a_d, cs, rd, wr). It sits between the user/edit logic and two bus engines, `FSM_ESC_RTC` (write) and the RTC read engine. It issues one-cycle start strobes, and gives user writes priority over a free-running periodic read. It owns the bus mux, so exactly one engine drives the RTC at a time, with idle guard gaps between transactions.

## Interface
- `READ_PERIOD`, default 10_000_000: clk cycles between periodic read requests.
- `TIMEOUT`, default 4096: max cycles to wait for an engine done before abort.
- `GUARD_CYC`, default 4: idle-bus cycles after every transaction.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_esc`  in  1  one-cycle request to write RTC registers.
- `esc_sel`  in  2  write group, sampled with `req_esc`: 01 hora, 10 fecha, 11 timer, 00 ignored (request dropped).
- `esc_done`, `lee_done`  in  1  one-cycle completion pulses from the write and read engines.
- `a_d_esc`, `cs_esc`, `rd_esc`, `wr_esc`  in  1 each  bus signals from the write engine.
- `a_d_lee`, `cs_lee`, `rd_lee`, `wr_lee`  in  1 each  bus signals from the read engine.
- `do_it_esc`, `do_it_lee`  out  1  one-cycle start strobes.
- `estado_hora`, `estado_fecha`, `estado_timer`  out  1 each  one-hot write group, held stable for the whole write.
- `a_d`, `cs`, `rd`, `wr`  out  1 each  muxed RTC bus.
- `busy`  out  1  high whenever state is not IDLE.
- `abort`  out  1  one-cycle pulse on timeout; resets the stuck engine.
- `err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- States: IDLE, START_ESC, WAIT_ESC, START_LEE, WAIT_LEE, GUARD.
- `pend_esc`:
  - Set on `req_esc` with `esc_sel`≠00; `esc_sel` is captured into `sel_q`.
  - Cleared on entering START_ESC.
  - Set wins over clear in the same cycle, so a request during a write queues exactly one more write. A later `sel_q` overwrites an earlier pending one.
- Period counter:
  - Counts 0..READ_PERIOD-1 and wraps.
  - At wrap it sets `pend_lee`. It does not accumulate: a wrap while pending is lost.
  - Counts in every state.
- Transitions:
  - IDLE → START_ESC if `pend_esc`.
  - Otherwise IDLE → START_LEE if `pend_lee`. Write has priority on ties.
- START_ESC:
  - Lasts one cycle and loads `estado_*` from `sel_q`.
  - `do_it_esc`=1, then → WAIT_ESC.
- START_LEE: one cycle, `do_it_lee`=1, clears `pend_lee`, then → WAIT_LEE.
- WAIT_x → GUARD on `x_done`.
- GUARD holds GUARD_CYC cycles, then → IDLE. `estado_*` clears to 0 on GUARD entry.
- Bus mux, selected from state:
  - START_ESC/WAIT_ESC use the esc engine signals.
  - START_LEE/WAIT_LEE use the lee engine signals.
  - Otherwise the bus is idle: `a_d`=`cs`=`rd`=`wr`=1.
- Done pulses are ignored outside the matching WAIT state.

## Timing
- Reset values: state IDLE, all strobes 0, `estado_*`=0, `busy`=0, `abort`=0, `err`=0, bus outputs 1, counter 0, pend flags 0.
- `req_esc` at cycle n in IDLE: `do_it_esc`=1 at n+2 (n+1 latch, n+2 START_ESC).
- `esc_done` at cycle m: GUARD during m+1..m+GUARD_CYC, IDLE at m+GUARD_CYC+1. Same rule for `lee_done`.
- Bus mux is combinational from registered state, so there is no extra latency.
- Reset mid-transaction: the bus goes idle immediately (asynchronous) and pending requests are discarded.

## Configuration
- `RTC_SCHED_TIMEOUT_EN` defined:
  - A wait counter runs in WAIT_x.
  - On reaching TIMEOUT cycles without done: `abort` pulses, `err` sets, → GUARD.
- Not defined:
  - WAIT_x waits indefinitely.
  - `abort` and `err` are tied to 0.
  - No wait counter is synthesized.

## Structure
- Shared package `rtc_pkg` holds:
  - the state encoding;
  - the `esc_sel` codes (SEL_HORA=01, SEL_FECHA=10, SEL_TIMER=11);
  - the bus idle constant.
- One sub-module, `rtc_period_timer`: the READ_PERIOD counter and wrap pulse.
- The bus mux and FSM stay in the top module.

## Test plan
Bench parameters: READ_PERIOD=50, TIMEOUT=20, GUARD_CYC=4, with engine models returning done 10 cycles after start.

- Reset release with no requests → first `do_it_lee` at cycle 51. Bus stays 1/1/1/1 except during WAIT_LEE. Reads repeat every 50 cycles.
- `req_esc`, `esc_sel`=10 → `do_it_esc` 2 cycles later. `estado_fecha`=1 from START_ESC until done. Bus follows the `*_esc` inputs.
- `req_esc` on the same cycle the period counter wraps → write first, then the read starts exactly 4 guard cycles after `esc_done`+1.
- Second `req_esc` (sel 11) during WAIT_ESC → a second write with `estado_timer`=1 follows the guard. No third write occurs.
- Engine never returns done, macro defined → `abort` pulse and `err`=1 after 20 cycles, then GUARD, then IDLE. Macro undefined → `busy` stays 1.
- `reset` asserted during WAIT_LEE → bus goes to all-1 with no clock edge needed. All flags are 0 after release.
